// File: rtl/pre_if_stage_pkg.sv
// Shared CPU definitions for the pre-IF (next-PC) stage: state encoding,
// reset fetch address and instruction step.
package pre_if_stage_pkg;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } pre_if_st_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;
    localparam logic [31:0] INST_STEP    = 32'd4;

endpackage

// File: rtl/pre_if_stage.sv
// Pre-IF stage: picks nextpc, drives the instruction SRAM read and buffers a
// redirect that could not be issued. Optional: PREIF_ALIGN_CHECK_EN flags misaligned fetches.
module pre_if_stage
    import pre_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fs_allow_in,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        to_fs_valid,
    output logic [31:0] pc,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic        br_taken_cancel,
    output logic        fetch_adef
);

    // Handshake: a fetch is accepted in any cycle where to_fs_valid and
    // fs_allow_in are both high; inst_sram_en marks that cycle.
    pre_if_st_e  st_q, st_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] br_buf_q, br_buf_d;
    logic [31:0] nextpc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q     <= ST_RST;
            pc_q     <= RESET_PC - INST_STEP;
            br_buf_q <= '0;
        end else begin
            st_q     <= st_d;
            pc_q     <= pc_d;
            br_buf_q <= br_buf_d;
        end
    end

    always_comb begin
        to_fs_valid = (st_q != ST_RST);
        inst_sram_en = to_fs_valid && fs_allow_in;

        if (br_taken) begin
            nextpc = br_target;
        end else if (st_q == ST_REDIR) begin
            nextpc = br_buf_q;
        end else begin
            nextpc = pc_q + INST_STEP;
        end

        st_d     = st_q;
        pc_d     = pc_q;
        br_buf_d = br_buf_q;
        if (st_q == ST_RST) begin
            st_d = ST_RUN;
        end else if (inst_sram_en) begin
            // A redirect arriving with the handshake is issued directly.
            pc_d = nextpc;
            st_d = ST_RUN;
        end else if (br_taken) begin
            br_buf_d = br_target;
            st_d     = ST_REDIR;
        end
    end

    assign pc              = pc_q;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_we    = 4'b0000;
    assign br_taken_cancel = br_taken;

`ifdef PREIF_ALIGN_CHECK_EN
    assign fetch_adef = inst_sram_en && (nextpc[1:0] != 2'b00);
`else
    assign fetch_adef = 1'b0;
`endif

endmodule

// File: tb/tb_pre_if_stage.sv
// Bench for pre_if_stage: directed fetch/stall/redirect/reset scenarios plus
// randomized traffic compared against a fetch-stream reference model.
module tb_pre_if_stage;

  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic        clk;
  logic        reset;
  logic        fs_allow_in;
  logic        br_taken;
  logic [31:0] br_target;
  logic        to_fs_valid;
  logic [31:0] pc;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic        br_taken_cancel;
  logic        fetch_adef;

  pre_if_stage #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .fs_allow_in     (fs_allow_in),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .to_fs_valid     (to_fs_valid),
    .pc              (pc),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .br_taken_cancel (br_taken_cancel),
    .fetch_adef      (fetch_adef)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: fetch stream view
  bit          m_running;
  logic [31:0] m_last_fetch;
  logic [31:0] redir_q[$];
  logic [31:0] fetch_q[$];
  logic [31:0] exp_q[$];

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_running    = 1'b0;
    m_last_fetch = RST_PC - 32'd4;
    redir_q.delete();
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step(input logic allow, input logic bt, input logic [31:0] tgt);
    logic [31:0] exp_addr;
    logic        exp_en;
    logic        exp_adef;
    fs_allow_in = allow;
    br_taken    = bt;
    br_target   = tgt;
    #1;
    if (bt) exp_addr = tgt;
    else if (redir_q.size() != 0) exp_addr = redir_q[0];
    else exp_addr = m_last_fetch + 32'd4;
    exp_en = m_running && allow;
`ifdef PREIF_ALIGN_CHECK_EN
    exp_adef = exp_en && (exp_addr[1:0] != 2'b00);
`else
    exp_adef = 1'b0;
`endif
    check("to_fs_valid", 32'(to_fs_valid), 32'(m_running));
    check("inst_sram_en", 32'(inst_sram_en), 32'(exp_en));
    check("inst_sram_addr", inst_sram_addr, exp_addr);
    check("pc", pc, m_last_fetch);
    check("cancel", 32'(br_taken_cancel), 32'(bt));
    check("fetch_adef", 32'(fetch_adef), 32'(exp_adef));
    check("inst_sram_we", 32'(inst_sram_we), 32'd0);
    if (inst_sram_en) fetch_q.push_back(inst_sram_addr);
    @(posedge clk);
    if (!m_running) begin
      m_running = 1'b1;
    end else if (exp_en) begin
      m_last_fetch = exp_addr;
      redir_q.delete();
    end else if (bt) begin
      redir_q.delete();
      redir_q.push_back(tgt);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_to_fs_valid", 32'(to_fs_valid), 32'd0);
    check("rst_sram_en", 32'(inst_sram_en), 32'd0);
    check("rst_fetch_adef", 32'(fetch_adef), 32'd0);
    check("rst_pc", pc, RST_PC - 32'd4);
  endtask

  // Asserts reset a few ns into the low phase, so it is checked between edges.
  task automatic async_reset();
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic compare_fetches(input string tag);
    check({tag, "_count"}, 32'(fetch_q.size()), 32'(exp_q.size()));
    while (exp_q.size() != 0 && fetch_q.size() != 0) begin
      check(tag, fetch_q.pop_front(), exp_q.pop_front());
    end
    exp_q.delete();
    fetch_q.delete();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    fs_allow_in = 1'b0;
    br_taken = 1'b0;
    br_target = '0;
    model_reset();
    #2;
    check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset release, sequential fetch, then a 3-cycle stall at pc_r=1c000010
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);
    check("pc_at_stall", pc, 32'h1c000010);
    for (int i = 0; i < 3; i++) begin
      check("stall_addr", inst_sram_addr, 32'h1c000014);
      step(1'b0, 1'b0, '0);
    end
    step(1'b1, 1'b0, '0);
    exp_q = '{32'h1c000000, 32'h1c000004, 32'h1c000008, 32'h1c00000c,
              32'h1c000010, 32'h1c000014};
    compare_fetches("seq_fetch");

    // redirect accepted with the handshake
    step(1'b1, 1'b1, 32'h1c000100);
    step(1'b1, 1'b0, '0);
    exp_q = '{32'h1c000100, 32'h1c000104};
    compare_fetches("br_direct");

    // two buffered redirects, newest wins
    step(1'b0, 1'b1, 32'h1c000200);
    step(1'b0, 1'b1, 32'h1c000300);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    exp_q = '{32'h1c000300, 32'h1c000304};
    compare_fetches("br_buffered");

    // reset while a redirect is pending
    step(1'b0, 1'b1, 32'h1c000400);
    async_reset();
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    exp_q = '{32'h1c000000};
    compare_fetches("redir_reset");

    // misaligned target, then realign immediately
    step(1'b1, 1'b1, 32'h1c000102);
    step(1'b1, 1'b1, 32'h1c000200);
    step(1'b1, 1'b0, '0);

    // wrap of the sequential increment
    step(1'b1, 1'b1, 32'hfffffffc);
    step(1'b1, 1'b0, '0);
    exp_q = '{32'h1c000102, 32'h1c000200, 32'h1c000204, 32'hfffffffc, 32'h00000000};
    compare_fetches("adef_wrap");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic        r_allow;
      logic        r_bt;
      logic [31:0] r_tgt;
      r_allow = ($urandom_range(0, 3) != 0);
      r_bt    = ($urandom_range(0, 4) == 0);
      r_tgt   = $urandom();
      if ($urandom_range(0, 3) != 0) r_tgt[1:0] = 2'b00;
      if ($urandom_range(0, 99) == 0) async_reset();
      else step(r_allow, r_bt, r_tgt);
    end
    fetch_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
